// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM encoding and one-hot grant selects shared by the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_INST = 2'd1,
        RD_DATA = 2'd2
    } state_t;
    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_LD   = 3'b001;
    localparam logic [2:0] GNT_DATA = 3'b010;
    localparam logic [2:0] GNT_INST = 3'b100;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: loader-first picker with data/inst alternation so fetch cannot starve
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic       i_en,
    input  logic       i_ld,
    input  logic       i_data,
    input  logic       i_inst,
    input  logic       i_last_data,
    output logic [2:0] o_gnt
);
    // inst overtakes data only when the previous core grant went to data
    always_comb begin
        o_gnt = GNT_NONE;
        if (i_en)
            o_gnt = i_ld ? GNT_LD :
                    (i_inst && (!i_data || i_last_data)) ? GNT_INST :
                    i_data ? GNT_DATA : GNT_NONE;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory among fetch, data and loader ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_ce_i,
    input  logic [AW-1:0] inst_addr_i,
    output logic [DW-1:0] inst_o,
    output logic          inst_valid_o,
    input  logic          data_ce_i,
    input  logic          data_we_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic [DW-1:0] data_rdata_o,
    output logic          data_valid_o,
    input  logic          ld_req_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i,
    output logic          ld_ack_o,
    output logic          stall_o,
    output logic          mem_ce_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [31:0]   stall_cnt_o
);
    state_t        r_state, w_next;
    logic          r_last_data, r_inst_valid, r_data_valid, r_ld_ack;
    logic [DW-1:0] r_inst, r_data;
    logic [31:0]   r_stall_cnt;
    logic [2:0]    w_gnt;
    logic          w_ld_elig, w_data_elig, w_inst_elig;

    assign w_ld_elig    = ld_req_i & ~r_ld_ack;
    assign w_data_elig  = data_ce_i & ~r_data_valid;
    assign w_inst_elig  = inst_ce_i & ~r_inst_valid;
    assign stall_o      = (inst_ce_i & ~r_inst_valid) | (data_ce_i & ~r_data_valid) | ld_req_i;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_inst_valid;
    assign data_rdata_o = r_data;
    assign data_valid_o = r_data_valid;
    assign ld_ack_o     = r_ld_ack;
    assign stall_cnt_o  = r_stall_cnt;

    mem_arb_grant u_grant (
        .i_en        (r_state == IDLE),
        .i_ld        (w_ld_elig),
        .i_data      (w_data_elig),
        .i_inst      (w_inst_elig),
        .i_last_data (r_last_data),
        .o_gnt       (w_gnt)
    );

    // granted requester drives the memory port this cycle; reads park the FSM for one cycle
    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        w_next      = IDLE;
        if (w_gnt == GNT_LD) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = ld_addr_i;
            mem_wdata_o = ld_wdata_i;
        end
        if (w_gnt == GNT_DATA) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = data_we_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
            w_next      = data_we_i ? IDLE : RD_DATA;
        end
        if (w_gnt == GNT_INST) begin
            mem_ce_o   = 1'b1;
            mem_addr_o = inst_addr_i;
            w_next     = RD_INST;
        end
    end

    // FSM state, fairness bit, completion pulses and captured read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_data  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_ld_ack     <= 1'b0;
            r_inst       <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_next;
            if (w_gnt == GNT_DATA) r_last_data <= 1'b1;
            else if (w_gnt == GNT_INST) r_last_data <= 1'b0;
            r_inst_valid <= (r_state == RD_INST);
            r_data_valid <= (r_state == RD_DATA) || (w_gnt == GNT_DATA && data_we_i);
            r_ld_ack     <= (w_gnt == GNT_LD);
            if (r_state == RD_INST) r_inst <= mem_rdata_i;
            if (r_state == RD_DATA) r_data <= mem_rdata_i;
        end
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_stall_cnt <= '0;
        else if (stall_o && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and a randomized run against a timing model
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_ce_i = 1'b0;
    logic [31:0]   inst_addr_i = '0;
    logic [31:0]   inst_o;
    logic          inst_valid_o;
    logic          data_ce_i = 1'b0;
    logic          data_we_i = 1'b0;
    logic [31:0]   data_addr_i = '0;
    logic [31:0]   data_wdata_i = '0;
    logic [31:0]   data_rdata_o;
    logic          data_valid_o;
    logic          ld_req_i = 1'b0;
    logic [31:0]   ld_addr_i = '0;
    logic [31:0]   ld_wdata_i = '0;
    logic          ld_ack_o;
    logic          stall_o;
    logic          mem_ce_o;
    logic          mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i = '0;
    logic [31:0]   stall_cnt_o;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_valid_o(data_valid_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i), .ld_ack_o(ld_ack_o),
        .stall_o(stall_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_cnt_o(stall_cnt_o)
    );

    // unified synchronous-read memory, not affected by reset
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_ce_o) begin
            if (mem_we_o) mem[mem_addr_o[11:2]] <= mem_wdata_o;
            else mem_rdata_i <= mem[mem_addr_o[11:2]];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;
        data_we_i = 1'b0;
        ld_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
        step();
        ld_req_i = 1'b1;
        ld_addr_i = a;
        ld_wdata_i = d;
        step();
        chkb("preload_ack", ld_ack_o, 1'b1);
        ld_req_i = 1'b0;
    endtask

    function automatic logic [31:0] raddr();
        return 32'h400 + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    typedef struct {
        logic        ld, dce, dwe, ice;
        logic        ce, we;
        logic [31:0] addr;
        logic        stall;
    } vec_t;
    vec_t tv[8];

    logic [31:0] refm [0:15];
    int          cyc, free_at, iv_at, dv_at, la_at, g;
    logic [31:0] iv_dat, dv_dat, exp_addr, exp_wdata;
    bit          dv_rd, m_last, civ, cdv, cla, e_ld, e_d, e_i, m_stall, exp_we;
    int unsigned mcnt;

    initial begin
        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0};
        tv[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4,   1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1};
        tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1};
        tv[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1};
        tv[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            ld_addr_i = 32'h200;
            data_addr_i = 32'h100;
            inst_addr_i = 32'h4;
            ld_req_i = tv[i].ld;
            data_ce_i = tv[i].dce;
            data_we_i = tv[i].dwe;
            inst_ce_i = tv[i].ice;
            #1;
            chkb($sformatf("vec%0d_ce", i), mem_ce_o, tv[i].ce);
            chkb($sformatf("vec%0d_we", i), mem_we_o, tv[i].we);
            chk($sformatf("vec%0d_addr", i), mem_addr_o, tv[i].addr);
            chkb($sformatf("vec%0d_stall", i), stall_o, tv[i].stall);
        end

        // preload through the loader port; contents must survive later resets
        do_reset();
        ld_write(32'h0, 32'h0050_0093);
        ld_write(32'h4, 32'h1111_1111);
        for (int i = 0; i < 16; i++) begin
            refm[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
            ld_write(32'h400 + 32'(i) * 32'd4, refm[i]);
        end

        // single fetch from reset
        do_reset();
        inst_ce_i = 1'b1;
        inst_addr_i = 32'h0;
        #1;
        chkb("fetch_c0_ce", mem_ce_o, 1'b1);
        chk("fetch_c0_addr", mem_addr_o, 32'h0);
        chkb("fetch_c0_stall", stall_o, 1'b1);
        chk("fetch_c0_cnt", stall_cnt_o, 32'd0);
        step();
        chkb("fetch_c1_ce", mem_ce_o, 1'b0);
        chkb("fetch_c1_valid", inst_valid_o, 1'b0);
        step();
        chkb("fetch_c2_valid", inst_valid_o, 1'b1);
        chk("fetch_c2_inst", inst_o, 32'h0050_0093);
        chk("fetch_c2_cnt", stall_cnt_o, 32'd2);
        chkb("fetch_c2_stall", stall_o, 1'b0);
        inst_ce_i = 1'b0;
        step();
        chkb("fetch_c3_valid", inst_valid_o, 1'b0);
        chk("fetch_c3_inst_hold", inst_o, 32'h0050_0093);

        // data write then read back
        do_reset();
        data_ce_i = 1'b1;
        data_we_i = 1'b1;
        data_addr_i = 32'h100;
        data_wdata_i = 32'hDEAD_BEEF;
        #1;
        chkb("wr_ce", mem_ce_o, 1'b1);
        chkb("wr_we", mem_we_o, 1'b1);
        chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        step();
        chkb("wr_valid", data_valid_o, 1'b1);
        data_we_i = 1'b0;
        #1;
        chkb("wr_no_regrant", mem_ce_o, 1'b0);
        step();
        chkb("rd_ce", mem_ce_o, 1'b1);
        chkb("rd_we", mem_we_o, 1'b0);
        chk("rd_addr", mem_addr_o, 32'h100);
        step();
        chkb("rd_c1_valid", data_valid_o, 1'b0);
        step();
        chkb("rd_c2_valid", data_valid_o, 1'b1);
        chk("rd_c2_data", data_rdata_o, 32'hDEAD_BEEF);
        data_ce_i = 1'b0;

        // contention: data first, then alternation with inst
        do_reset();
        inst_ce_i = 1'b1;
        inst_addr_i = 32'h4;
        data_ce_i = 1'b1;
        data_we_i = 1'b0;
        data_addr_i = 32'h100;
        #1;
        chk("cont_c0_addr", mem_addr_o, 32'h100);
        step();
        chkb("cont_c1_ce", mem_ce_o, 1'b0);
        step();
        chkb("cont_c2_dvalid", data_valid_o, 1'b1);
        chk("cont_c2_addr", mem_addr_o, 32'h4);
        step();
        chkb("cont_c3_ce", mem_ce_o, 1'b0);
        step();
        chkb("cont_c4_ivalid", inst_valid_o, 1'b1);
        chk("cont_c4_inst", inst_o, 32'h1111_1111);
        chk("cont_c4_addr", mem_addr_o, 32'h100);
        step();
        step();
        chkb("cont_c6_dvalid", data_valid_o, 1'b1);
        chkb("cont_c6_ce", mem_ce_o, 1'b1);
        chk("cont_c6_addr", mem_addr_o, 32'h4);
        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;

        // loader beats both core ports
        do_reset();
        ld_req_i = 1'b1;
        ld_addr_i = 32'h8;
        ld_wdata_i = 32'hCAFE_F00D;
        inst_ce_i = 1'b1;
        inst_addr_i = 32'h0;
        data_ce_i = 1'b1;
        data_addr_i = 32'h100;
        #1;
        chk("ld_c0_addr", mem_addr_o, 32'h8);
        chkb("ld_c0_we", mem_we_o, 1'b1);
        chk("ld_c0_wdata", mem_wdata_o, 32'hCAFE_F00D);
        chkb("ld_c0_stall", stall_o, 1'b1);
        step();
        chkb("ld_c1_ack", ld_ack_o, 1'b1);
        chkb("ld_c1_stall", stall_o, 1'b1);
        chk("ld_c1_addr", mem_addr_o, 32'h100);
        chkb("ld_c1_we", mem_we_o, 1'b0);
        ld_req_i = 1'b0;
        step();
        chkb("ld_c2_ack", ld_ack_o, 1'b0);
        chkb("ld_c2_stall", stall_o, 1'b1);
        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;

        // reset in the middle of a data read
        do_reset();
        data_ce_i = 1'b1;
        data_addr_i = 32'h8;
        #1;
        chkb("mid_c0_ce", mem_ce_o, 1'b1);
        step();
        rst = 1'b0;
        data_ce_i = 1'b0;
        #1;
        chkb("mid_valid", data_valid_o, 1'b0);
        chk("mid_rdata", data_rdata_o, 32'h0);
        chk("mid_inst", inst_o, 32'h0);
        chk("mid_cnt", stall_cnt_o, 32'h0);
        chkb("mid_ce", mem_ce_o, 1'b0);
        step();
        chkb("mid_after_valid", data_valid_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        data_ce_i = 1'b1;
        #1;
        chkb("mid_idle_grant", mem_ce_o, 1'b1);
        step();
        step();
        chkb("mid_reread_valid", data_valid_o, 1'b1);
        chk("mid_reread_data", data_rdata_o, 32'hCAFE_F00D);
        data_ce_i = 1'b0;

        // stall counter saturation
        do_reset();
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        #1;
        chk("sat_preset", stall_cnt_o, 32'hFFFF_FFFE);
        ld_req_i = 1'b1;
        ld_addr_i = 32'h3C;
        ld_wdata_i = 32'h0;
        step();
        chk("sat_c1", stall_cnt_o, 32'hFFFF_FFFF);
        step();
        step();
        chk("sat_c3", stall_cnt_o, 32'hFFFF_FFFF);
        chkb("sat_stall", stall_o, 1'b1);
        ld_req_i = 1'b0;

        // randomized traffic against a cycle-level timing model
        do_reset();
        cyc = -1;
        free_at = 0;
        iv_at = -1;
        dv_at = -1;
        la_at = -1;
        m_last = 1'b0;
        dv_rd = 1'b0;
        mcnt = 0;
        iv_dat = '0;
        dv_dat = '0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (!inst_ce_i) begin
                if ($urandom_range(0, 2) == 0) begin inst_ce_i = 1'b1; inst_addr_i = raddr(); end
            end else if (iv_at == cyc) begin
                if ($urandom_range(0, 1) == 0) inst_ce_i = 1'b0;
                else inst_addr_i = raddr();
            end
            if (!data_ce_i || dv_at == cyc) begin
                if (data_ce_i && $urandom_range(0, 1) == 0) data_ce_i = 1'b0;
                else if (data_ce_i || $urandom_range(0, 2) == 0) begin
                    data_ce_i = 1'b1;
                    data_we_i = 1'($urandom_range(0, 1));
                    data_addr_i = raddr();
                    data_wdata_i = $urandom;
                end
            end
            if (!ld_req_i) begin
                if ($urandom_range(0, 7) == 0) begin ld_req_i = 1'b1; ld_addr_i = raddr(); ld_wdata_i = $urandom; end
            end else if (la_at == cyc) begin
                ld_req_i = 1'b0;
            end
            @(negedge clk);
            civ = (iv_at == cyc);
            cdv = (dv_at == cyc);
            cla = (la_at == cyc);
            e_ld = ld_req_i && !cla;
            e_d = data_ce_i && !cdv;
            e_i = inst_ce_i && !civ;
            g = 0;
            if (cyc >= free_at) g = e_ld ? 1 : (e_i && (!e_d || m_last)) ? 3 : e_d ? 2 : 0;
            m_stall = e_i || e_d || ld_req_i;
            exp_addr = (g == 1) ? ld_addr_i : (g == 2) ? data_addr_i : inst_addr_i;
            exp_we = (g == 1) || (g == 2 && data_we_i);
            exp_wdata = (g == 1) ? ld_wdata_i : data_wdata_i;
            chkb("rnd_ivalid", inst_valid_o, civ);
            chkb("rnd_dvalid", data_valid_o, cdv);
            chkb("rnd_ldack", ld_ack_o, cla);
            chkb("rnd_stall", stall_o, m_stall);
            chk("rnd_cnt", stall_cnt_o, mcnt);
            chkb("rnd_ce", mem_ce_o, g != 0);
            if (civ) chk("rnd_inst", inst_o, iv_dat);
            if (cdv && dv_rd) chk("rnd_rdata", data_rdata_o, dv_dat);
            if (g != 0) begin
                chk("rnd_addr", mem_addr_o, exp_addr);
                chkb("rnd_we", mem_we_o, exp_we);
                if (exp_we) chk("rnd_wdata", mem_wdata_o, exp_wdata);
            end
            if (g == 1) begin
                refm[ld_addr_i[5:2]] = ld_wdata_i;
                la_at = cyc + 1;
            end else if (g == 2) begin
                m_last = 1'b1;
                if (data_we_i) begin
                    refm[data_addr_i[5:2]] = data_wdata_i;
                    dv_at = cyc + 1;
                    dv_rd = 1'b0;
                end else begin
                    dv_dat = refm[data_addr_i[5:2]];
                    dv_at = cyc + 2;
                    dv_rd = 1'b1;
                    free_at = cyc + 2;
                end
            end else if (g == 3) begin
                m_last = 1'b0;
                iv_dat = refm[inst_addr_i[5:2]];
                iv_at = cyc + 2;
                free_at = cyc + 2;
            end
            if (m_stall) mcnt++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
